// File: rtl/selector_pkg.sv
// Shared state encoding and width helper for the N-way registered selector.
package selector_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Ceiling log2, never below 1, so that a select field always has at least one bit.
    function automatic int sel_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/selector_nway_comb.sv
// Purely combinational NUM_IN:1 mux. Out-of-range selects give an all-zero word and drop in_range.
module selector_nway_comb #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_IN*WIDTH-1:0] data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        dout,
    output logic                    in_range
);

    localparam logic [SEL_W:0] LIMIT = (SEL_W+1)'(NUM_IN);

    always_comb begin
        dout     = '0;
        in_range = ({1'b0, sel} < LIMIT);
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) dout = data[k*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/selector_n_skid.sv
// Registered N-way selector feeding a 2-entry skid buffer (head + skid register).
// Define SELECTOR_SEL_ERR_EN to drop out-of-range beats and pulse sel_error instead of enqueuing zero.
module selector_n_skid
    import selector_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = sel_clog2(NUM_IN)
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic [NUM_IN*WIDTH-1:0] DataIn,
    input  logic [SEL_W-1:0]        selection,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        DataOut,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_error
);

    state_t           state, state_n;
    logic [WIDTH-1:0] head, head_n;
    logic [WIDTH-1:0] skid, skid_n;
    logic [WIDTH-1:0] sel_data;
    logic             in_range;
    logic             acc, enq, pop;

    selector_nway_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_mux (
        .data     (DataIn),
        .sel      (selection),
        .dout     (sel_data),
        .in_range (in_range)
    );

    // Ready depends only on registered state, so no comb path from out_ready.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign DataOut   = head;

    assign acc = in_valid & in_ready;
    assign pop = out_valid & out_ready;

`ifdef SELECTOR_SEL_ERR_EN
    logic sel_err_q;

    assign enq       = acc & in_range;
    assign sel_error = sel_err_q;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) sel_err_q <= 1'b0;
        else       sel_err_q <= acc & ~in_range;
    end
`else
    logic unused_range;

    assign enq          = acc;
    assign sel_error    = 1'b0;
    assign unused_range = in_range;
`endif

    always_comb begin
        state_n = state;
        head_n  = head;
        skid_n  = skid;
        case (state)
            EMPTY: begin
                if (enq) begin
                    state_n = ONE;
                    head_n  = sel_data;
                end
            end
            ONE: begin
                if (enq && pop) begin
                    head_n = sel_data;
                end else if (enq) begin
                    state_n = FULL;
                    skid_n  = sel_data;
                end else if (pop) begin
                    state_n = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_n = ONE;
                    head_n  = skid;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            state <= state_n;
            head  <= head_n;
            skid  <= skid_n;
        end
    end

endmodule

// File: tb/tb_selector_n_skid.sv
// Directed bench: 3-way instance for the main scenarios plus a 2-way instance.
module tb_selector_n_skid;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [95:0] DataIn;
    logic [1:0]  selection;
    logic        in_valid, in_ready, out_valid, out_ready, sel_error;
    logic [31:0] DataOut;

    logic [63:0] d2_in;
    logic        sel2, v2, rdy2, ov2, or2, err2;
    logic [31:0] do2;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    selector_n_skid #(.WIDTH(32), .NUM_IN(3)) u_dut (
        .CLK(CLK), .Reset(Reset), .DataIn(DataIn), .selection(selection),
        .in_valid(in_valid), .in_ready(in_ready), .DataOut(DataOut),
        .out_valid(out_valid), .out_ready(out_ready), .sel_error(sel_error)
    );

    selector_n_skid #(.WIDTH(32), .NUM_IN(2)) u_dut2 (
        .CLK(CLK), .Reset(Reset), .DataIn(d2_in), .selection(sel2),
        .in_valid(v2), .in_ready(rdy2), .DataOut(do2),
        .out_valid(ov2), .out_ready(or2), .sel_error(err2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [1:0]  seq [4];
        logic [31:0] exp [4];
        seq = '{2'd0, 2'd1, 2'd2, 2'd0};
        exp = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h11111111};

        Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; selection = '0;
        DataIn = {32'h33333333, 32'h22222222, 32'h11111111};
        d2_in = {32'hBBBB0002, 32'hAAAA0001}; sel2 = 1'b0; v2 = 1'b0; or2 = 1'b1;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_dataout",   DataOut,        32'd0);
        chk("rst_sel_error", 32'(sel_error), 32'd0);
        Reset = 1'b0;
        tick();

        // streaming, no bubbles
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            selection = seq[i]; in_valid = 1'b1;
            tick();
            chk($sformatf("stream_data%0d", i), DataOut, exp[i]);
            chk($sformatf("stream_vld%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("stream_rdy%0d", i), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain", 32'(out_valid), 32'd0);

        // backpressure into FULL
        out_ready = 1'b0; selection = 2'd0; in_valid = 1'b1;
        DataIn[31:0] = 32'hAAAA0001;
        tick();
        chk("bp_one_data", DataOut, 32'hAAAA0001);
        DataIn[31:0] = 32'hAAAA0002;
        tick();
        chk("bp_full_rdy",  32'(in_ready), 32'd0);
        chk("bp_full_data", DataOut, 32'hAAAA0001);
        DataIn[31:0] = 32'hAAAA0003;
        tick();
        chk("bp_hold_data", DataOut, 32'hAAAA0001);
        chk("bp_hold_vld",  32'(out_valid), 32'd1);
        chk("bp_hold_rdy",  32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_pop1_data", DataOut, 32'hAAAA0002);
        chk("bp_pop1_rdy",  32'(in_ready), 32'd1);
        // accept + pop in ONE: stays ONE, head takes the new beat
        tick();
        chk("acc_pop_data", DataOut, 32'hAAAA0003);
        chk("acc_pop_vld",  32'(out_valid), 32'd1);
        chk("acc_pop_rdy",  32'(in_ready), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("bp_drain", 32'(out_valid), 32'd0);

        // reset while FULL
        out_ready = 1'b0; in_valid = 1'b1; DataIn[31:0] = 32'h5A5A5A5A;
        tick(); tick();
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        Reset = 1'b1;
        #1;
        chk("mid_rst_vld",  32'(out_valid), 32'd0);
        chk("mid_rst_data", DataOut, 32'd0);
        tick();
        Reset = 1'b0;
        tick();
        chk("post_rst_rdy", 32'(in_ready),  32'd1);
        chk("post_rst_vld", 32'(out_valid), 32'd0);
        chk("post_rst_err", 32'(sel_error), 32'd0);

        // out-of-range selection
        DataIn = {3{32'hDEADBEEF}}; out_ready = 1'b1; selection = 2'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; selection = 2'd0;
`ifdef SELECTOR_SEL_ERR_EN
        chk("oor_vld", 32'(out_valid), 32'd0);
        chk("oor_err", 32'(sel_error), 32'd1);
        tick();
        chk("oor_err_clr", 32'(sel_error), 32'd0);
`else
        chk("oor_vld",  32'(out_valid), 32'd1);
        chk("oor_data", DataOut, 32'd0);
        chk("oor_err",  32'(sel_error), 32'd0);
        tick();
        chk("oor_drain", 32'(out_valid), 32'd0);
`endif

        // 2-way instance
        sel2 = 1'b1; v2 = 1'b1;
        tick();
        chk("two_sel1", do2, 32'hBBBB0002);
        chk("two_vld",  32'(ov2), 32'd1);
        sel2 = 1'b0;
        tick();
        chk("two_sel0", do2, 32'hAAAA0001);
        chk("two_err",  32'(err2), 32'd0);
        v2 = 1'b0;
        tick();
        chk("two_drain", 32'(ov2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
